// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared state encoding, defaults and width helper for the stopwatch sequencer
package sw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    localparam int TICK_DIV_DEF = 1_000_000;
    localparam int SCAN_DIV_DEF = 100_000;

    // ceil(log2(n)) with a floor of one bit, so a counter of this width holds 0..n-1
    function automatic int sw_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sw_btn_edge.sv
// rtl/sw_btn_edge.sv - button synchronizer with one-shot rising-edge detect
module sw_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic primed_q;
    logic armed_q;

    // Two-flop synchronizer, history flop for edge detect, and an arm flag that
    // only sets once a genuine low sample has been seen after reset, so a
    // button held through reset release cannot fire until pressed again.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            primed_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            primed_q <= 1'b1;
            if (primed_q && !sync1_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign rise_o = sync2_q & ~prev_q & armed_q;

endmodule

// File: rtl/sw_sequencer.sv
// rtl/sw_sequencer.sv - stopwatch control FSM with tick and display-scan prescalers
module sw_sequencer
    import sw_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       add,
    output logic       cen,
    output logic       clr,
    output logic       freeze,
    output logic [1:0] digit_sel,
    output logic [1:0] state
);

    localparam int TW = sw_width(TICK_DIV);
    localparam int SW = sw_width(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic start_ev;
    logic stop_ev;
    logic add_ev;

    sw_btn_edge u_start (.clk(clk), .rst(rst), .btn_i(start), .rise_o(start_ev));
    sw_btn_edge u_stop  (.clk(clk), .rst(rst), .btn_i(stop),  .rise_o(stop_ev));
    sw_btn_edge u_add   (.clk(clk), .rst(rst), .btn_i(add),   .rise_o(add_ev));

    sw_state_e       state_q;
    sw_state_e       state_d;
    logic [TW-1:0]   tick_q;
    logic [SW-1:0]   scan_q;
    logic [1:0]      digit_q;
    logic            cen_q;
    logic            clr_q;
    logic            freeze_q;
    logic            running;

    assign running = (state_q == ST_RUN) || (state_q == ST_LAP);

    // Next state: within each state the checks run stop, start, add, so the
    // highest-priority event that is legal here wins and the rest are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ev) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop_ev)     state_d = ST_PAUSE;
                else if (add_ev) state_d = ST_LAP;
            end
            ST_PAUSE: begin
                if (start_ev)    state_d = ST_RUN;
                else if (add_ev) state_d = ST_IDLE;
            end
            ST_LAP: begin
                if (stop_ev)     state_d = ST_PAUSE;
                else if (add_ev) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, registered outputs and tick prescaler (held in PAUSE, cleared on entry to IDLE)
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            cen_q    <= 1'b0;
            clr_q    <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            clr_q    <= (state_q == ST_PAUSE) && (state_d == ST_IDLE);
            freeze_q <= (state_d == ST_LAP);
            cen_q    <= running && (tick_q == TICK_LAST);
            if (state_d == ST_IDLE) begin
                tick_q <= '0;
            end else if (running) begin
                tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
            end
        end
    end

    // Free-running display scan: advance the digit index every SCAN_DIV cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_q  <= '0;
            digit_q <= 2'd0;
        end else if (scan_q == SCAN_LAST) begin
            scan_q  <= '0;
            digit_q <= digit_q + 2'd1;
        end else begin
            scan_q  <= scan_q + SW'(1);
        end
    end

    assign cen       = cen_q;
    assign clr       = clr_q;
    assign freeze    = freeze_q;
    assign digit_sel = digit_q;
    assign state     = state_q;

endmodule

// File: tb/tb_sw_sequencer.sv
// tb/tb_sw_sequencer.sv - scoreboard bench for sw_sequencer against a cycle reference model
module tb_sw_sequencer;

    localparam int TD = 4;
    localparam int SD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       add = 1'b0;
    logic       cen;
    logic       clr;
    logic       freeze;
    logic [1:0] digit_sel;
    logic [1:0] state;

    sw_sequencer #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .add(add),
        .cen(cen), .clr(clr), .freeze(freeze), .digit_sel(digit_sel), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       cen;
        logic       clr;
        logic       frz;
        logic [1:0] dig;
    } obs_t;

    obs_t exp_q[$];

    // reference model state
    int   nxt_tbl [4][3];   // [state][button: 0 stop, 1 start, 2 add], -1 = ignored
    bit   h [3][3];         // per button: samples taken 1, 2, 3 edges ago
    bit   pins [3];
    int   m_st, m_ns, m_run, m_edges, m_n;
    bit   m_acted, m_running;
    obs_t m_o;

    // scoreboard state
    int   n_err = 0;
    int   n_checks = 0;
    int   n_trans = 0;
    logic [1:0] prev_st = 2'd0;
    bit   win_checked = 0;
    bit   done = 0;
    obs_t e_o, a_o;

    // driver handshakes
    bit   win = 0;
    bit   win_done = 0;
    bit   end_req = 0;

    // Reference model: one step per rising edge, expected post-edge outputs queued
    initial begin
        for (int s = 0; s < 4; s++) for (int b = 0; b < 3; b++) nxt_tbl[s][b] = -1;
        nxt_tbl[0][1] = 1;
        nxt_tbl[1][0] = 2;  nxt_tbl[1][2] = 3;
        nxt_tbl[2][1] = 1;  nxt_tbl[2][2] = 0;
        nxt_tbl[3][0] = 2;  nxt_tbl[3][2] = 1;
        m_st = 0; m_run = 0; m_edges = 0; m_n = 0;
        forever begin
            @(posedge clk);
            pins[0] = stop; pins[1] = start; pins[2] = add;
            if (!rst) begin
                m_st = 0; m_run = 0; m_edges = 0; m_n = 0;
                for (int b = 0; b < 3; b++) for (int j = 0; j < 3; j++) h[b][j] = 0;
                m_o = '0;
            end else begin
                // a press acts two edges after the edge that first sampled it high,
                // provided a low sample since reset came just before it
                m_ns = m_st; m_acted = 0;
                for (int b = 0; b < 3; b++) begin
                    if (!m_acted && m_n >= 3 && h[b][1] && !h[b][2] && nxt_tbl[m_st][b] >= 0) begin
                        m_ns = nxt_tbl[m_st][b];
                        m_acted = 1;
                    end
                end
                m_running = (m_st == 1) || (m_st == 3);
                if (m_running) m_run++;
                m_o.cen = m_running && (m_run % TD == 0);
                if (m_ns == 0) m_run = 0;
                m_o.clr = (m_st == 2) && (m_ns == 0);
                m_st = m_ns;
                m_o.st = 2'(m_ns);
                m_o.frz = (m_ns == 3);
                m_edges++;
                m_o.dig = 2'((m_edges / SD) % 4);
                for (int b = 0; b < 3; b++) begin
                    h[b][2] = h[b][1];
                    h[b][1] = h[b][0];
                    h[b][0] = pins[b];
                end
                m_n++;
            end
            exp_q.push_back(m_o);
        end
    end

    // Monitor: pop and compare on the falling edge, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e_o = exp_q.pop_front();
                a_o = {state, cen, clr, freeze, digit_sel};
                n_checks++;
                if (a_o !== e_o) begin
                    n_err++;
                    $display("FAIL outputs t=%0t got st=%0d cen=%0b clr=%0b frz=%0b dig=%0d want st=%0d cen=%0b clr=%0b frz=%0b dig=%0d",
                             $time, a_o.st, a_o.cen, a_o.clr, a_o.frz, a_o.dig,
                             e_o.st, e_o.cen, e_o.clr, e_o.frz, e_o.dig);
                end
                if (win && a_o.st != prev_st) n_trans++;
                prev_st = a_o.st;
            end
            if (win_done && !win_checked) begin
                win_checked = 1;
                n_checks++;
                if (n_trans != 1) begin
                    n_err++;
                    $display("FAIL held_start_transitions got %0d want 1", n_trans);
                end
            end
            if (end_req && !done) begin
                n_checks++;
                if (exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL drain got %0d pending want 0", exp_q.size());
                end
                done = 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b, input int hold);
        case (b)
            0: stop = 1'b1;
            1: start = 1'b1;
            default: add = 1'b1;
        endcase
        tick(hold);
        stop = 1'b0; start = 1'b0; add = 1'b0;
    endtask

    // Stimulus
    initial begin
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(4);

        // start, then free-running ticks
        press(1, 3);
        tick(12);

        // lap and back to run
        press(2, 2);
        tick(8);
        press(2, 2);
        tick(6);

        // stop so the PAUSE transition lands two cycles into a tick, then resume
        for (int i = 0; i < 8 && !(m_st == 1 && m_run % TD == 3); i++) tick(1);
        press(0, 2);
        tick(6);
        press(1, 2);
        tick(8);

        // pause -> clear, then stop in IDLE is ignored
        press(0, 2);
        tick(4);
        press(2, 2);
        tick(4);
        press(0, 2);
        tick(4);

        // simultaneous stop and add in RUN
        press(1, 2);
        tick(6);
        stop = 1'b1; add = 1'b1;
        tick(2);
        stop = 1'b0; add = 1'b0;
        tick(4);
        press(2, 2);
        tick(4);

        // held start gives exactly one transition
        win = 1;
        start = 1'b1;
        tick(50);
        start = 1'b0;
        win = 0;
        win_done = 1;
        tick(4);

        // reset in LAP mid-tick with start held through release
        press(2, 2);
        tick(5);
        start = 1'b1;
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(10);
        start = 1'b0;
        tick(4);
        press(1, 2);
        tick(8);

        // randomized buttons with occasional reset
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) stop = ~stop;
            if ($urandom_range(0, 7) == 0) start = ~start;
            if ($urandom_range(0, 7) == 0) add = ~add;
        end
        rst = 1'b1; stop = 1'b0; start = 1'b0; add = 1'b0;
        tick(3);

        end_req = 1;
        for (int i = 0; i < 10 && !done; i++) tick(1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sw_sequencer.md
SW_SEQUENCER -- requirements
Module: sw_sequencer

Interface
REQ-001 Parameter: TICK_DIV, default 1_000_000, clk cycles per count tick (100 Hz at 100 MHz); legal range 2..2^24.
REQ-002 Parameter: SCAN_DIV, default 100_000, clk cycles per display digit step; legal range 2..2^24.
REQ-003 Port: clk  input  1  sole clock, all logic on its rising edge.
REQ-004 Port: rst  input  1  synchronous reset, active-low.
REQ-005 Port: start  input  1  asynchronous start button, level.
REQ-006 Port: stop  input  1  asynchronous stop button, level.
REQ-007 Port: add  input  1  asynchronous lap/clear button, level.
REQ-008 Port: cen  output  1  count-enable pulse to the time counter, one clk wide.
REQ-009 Port: clr  output  1  counter clear pulse, one clk wide.
REQ-010 Port: freeze  output  1  display hold; high = display shows the latched lap value.
REQ-011 Port: digit_sel  output  2  active display digit index, 0..3.
REQ-012 Port: state  output  2  current state encoding, for debug and LEDs.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer and a rising-edge detector; a pin rising before edge N changes the state at edge N+2; a held button produces exactly one event.
REQ-014 FSM states SHALL be IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-015 IDLE: start -> RUN; stop and add are ignored.
REQ-016 RUN: stop -> PAUSE; add -> LAP; start is ignored.
REQ-017 LAP: add -> RUN; stop -> PAUSE; start is ignored.
REQ-018 PAUSE: start -> RUN; add -> IDLE; stop is ignored.
REQ-019 Events in the same cycle SHALL be resolved with priority stop > start > add; only the highest-priority event that is legal in the current state acts, and the others are discarded.
REQ-020 clr SHALL be high for exactly the one cycle following the PAUSE->IDLE transition edge, and is never high otherwise.
REQ-021 freeze SHALL be high exactly while state == LAP.
REQ-022 The tick prescaler (width ceil(log2 TICK_DIV)) SHALL count only in RUN or LAP, hold its value in PAUSE, and be zero in IDLE.
REQ-023 cen SHALL pulse high for one cycle when the prescaler reaches TICK_DIV-1 in RUN or LAP, and the prescaler wraps to 0 on that cycle; the first cen occurs TICK_DIV cycles after entry to RUN from IDLE.
REQ-024 Resuming from PAUSE SHALL continue from the held prescaler value, so no partial tick is lost or duplicated.
REQ-025 The scan prescaler SHALL run freely in all states; digit_sel increments every SCAN_DIV cycles and wraps 3 -> 0.

Reset
REQ-026 While rst == 0 at a rising edge: state=IDLE, both prescalers=0, digit_sel=0, cen=0, clr=0, freeze=0, and synchronizer/edge flops=0.
REQ-027 Reset mid-operation (any state, mid-tick) SHALL take effect at that edge, with no cen or clr pulse on the following cycle.
REQ-028 A button held high across reset release SHALL NOT generate an event until it is released and pressed again.

Structure
REQ-029 Package sw_pkg SHALL hold the state encoding, the TICK_DIV/SCAN_DIV defaults, and the width-computing function.
REQ-030 Sub-module sw_btn_edge (synchronizer plus rising-edge detector, one per button) SHALL be instantiated three times.

Verification
REQ-031 TICK_DIV=4: reset, then press start -> state=1 two edges later; cen pulses every 4th cycle; first cen arrives 4 cycles after entering RUN.
REQ-032 In RUN, press add -> state=3 and freeze=1 while cen continues; press add again -> state=1 and freeze=0.
REQ-033 TICK_DIV=4: stop 2 cycles into a tick -> PAUSE with no cen; start -> RUN and the next cen arrives after exactly 2 cycles.
REQ-034 In PAUSE, press add -> state=0 and a single clr pulse; press stop in IDLE -> no change.
REQ-035 In RUN, press stop and add in the same cycle -> PAUSE with freeze=0; hold start for 50 cycles from IDLE -> exactly one transition.
REQ-036 Assert rst=0 in LAP mid-tick -> next cycle all outputs are 0 and state=0; start held through the release of reset causes no transition.
